// File: rtl/raster_pkg.sv
// Shared raster types, tile-grid defaults and small helpers for the binner and raster stage.
package raster_pkg;

    localparam int unsigned DEF_TILE_WIDTH   = 32;
    localparam int unsigned DEF_TILE_COLUMNS = 20;
    localparam int unsigned DEF_TILE_ROWS    = 15;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned DEPTH_W  = 8;
    localparam int unsigned COLOR_W  = 4;
    localparam int unsigned TILE_X_W = 5;
    localparam int unsigned TILE_Y_W = 4;
    localparam int unsigned PAD_W    = 3;
    localparam int unsigned AREA_W   = 22;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [DEPTH_W-1:0] z;
    } coord_3d_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_2d_t;

    typedef struct packed {
        logic [COLOR_W-1:0]  color;
        logic [PAD_W-1:0]    padding;
        logic [TILE_Y_W-1:0] tile_y;
        logic [TILE_X_W-1:0] tile_x;
    } polygon_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_EMIT  = 2'd2
    } binner_state_e;

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tile_binner_if.sv
// Triangle-in / tile-work-item-out handshake bundle of the tile binner.
interface tile_binner_if;
    import raster_pkg::*;

    logic               s_vld;
    logic               s_rdy;
    coord_3d_t          s_v0;
    coord_3d_t          s_v1;
    coord_3d_t          s_v2;
    logic [COLOR_W-1:0] s_color;

    logic               m_vld;
    logic               m_rdy;
    coord_3d_t          m_v0;
    coord_3d_t          m_v1;
    coord_3d_t          m_v2;
    polygon_t           m_meta;

    // Binner side: consumes triangles, produces work items.
    modport slave (
        input  s_vld, s_v0, s_v1, s_v2, s_color, m_rdy,
        output s_rdy, m_vld, m_v0, m_v1, m_v2, m_meta
    );

    // Environment side: upstream producer plus raster-stage consumer.
    modport master (
        output s_vld, s_v0, s_v1, s_v2, s_color, m_rdy,
        input  s_rdy, m_vld, m_v0, m_v1, m_v2, m_meta
    );

endinterface

// File: rtl/tile_bbox.sv
// Combinational screen bbox of a triangle: min/max, clamp to screen, tile range, offscreen flag.
module tile_bbox
    import raster_pkg::*;
#(
    parameter int unsigned TILE_WIDTH   = DEF_TILE_WIDTH,
    parameter int unsigned TILE_COLUMNS = DEF_TILE_COLUMNS,
    parameter int unsigned TILE_ROWS    = DEF_TILE_ROWS
) (
    input  coord_2d_t           p0_i,
    input  coord_2d_t           p1_i,
    input  coord_2d_t           p2_i,
    output logic [TILE_X_W-1:0] col_lo_c_o,
    output logic [TILE_X_W-1:0] col_hi_c_o,
    output logic [TILE_Y_W-1:0] row_lo_c_o,
    output logic [TILE_Y_W-1:0] row_hi_c_o,
    output logic                offscreen_c_o
);

    localparam int unsigned        SHIFT  = $clog2(TILE_WIDTH);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(TILE_COLUMNS * TILE_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(TILE_ROWS * TILE_WIDTH - 1);

    logic [COORD_W-1:0] xmin, xmax_raw, xmax;
    logic [COORD_W-1:0] ymin, ymax_raw, ymax;

    // Only the max edge is clamped; a min beyond the screen drops the whole triangle.
    always_comb begin
        xmin     = min3(p0_i.x, p1_i.x, p2_i.x);
        ymin     = min3(p0_i.y, p1_i.y, p2_i.y);
        xmax_raw = max3(p0_i.x, p1_i.x, p2_i.x);
        ymax_raw = max3(p0_i.y, p1_i.y, p2_i.y);
        xmax     = (xmax_raw > X_LAST) ? X_LAST : xmax_raw;
        ymax     = (ymax_raw > Y_LAST) ? Y_LAST : ymax_raw;

        col_lo_c_o    = TILE_X_W'(xmin >> SHIFT);
        col_hi_c_o    = TILE_X_W'(xmax >> SHIFT);
        row_lo_c_o    = TILE_Y_W'(ymin >> SHIFT);
        row_hi_c_o    = TILE_Y_W'(ymax >> SHIFT);
        offscreen_c_o = (xmin > X_LAST) || (ymin > Y_LAST);
    end

endmodule

// File: rtl/tile_binner.sv
// Tile binner: captures a triangle and emits one work item per covered tile, row-major.
// Optional back-face / degenerate culling when BINNER_BACKFACE_CULL_EN is defined.
module tile_binner
    import raster_pkg::*;
#(
    parameter int unsigned TILE_WIDTH   = DEF_TILE_WIDTH,
    parameter int unsigned TILE_COLUMNS = DEF_TILE_COLUMNS,
    parameter int unsigned TILE_ROWS    = DEF_TILE_ROWS
) (
    input  logic         clk,
    input  logic         rst_n,
    tile_binner_if.slave bin_if,
    output logic         busy
);

    binner_state_e       state_q;
    coord_3d_t           v0_q, v1_q, v2_q;
    logic [COLOR_W-1:0]  color_q;
    logic [TILE_X_W-1:0] col_lo_q, col_hi_q, tile_x_q;
    logic [TILE_Y_W-1:0] row_hi_q, tile_y_q;
    logic                m_vld_q, rdy_q, busy_q;

    coord_2d_t           p0_c, p1_c, p2_c;
    logic [TILE_X_W-1:0] col_lo_c, col_hi_c;
    logic [TILE_Y_W-1:0] row_lo_c, row_hi_c;
    logic                offscreen_c, cull_c;

    assign p0_c = '{x: v0_q.x, y: v0_q.y};
    assign p1_c = '{x: v1_q.x, y: v1_q.y};
    assign p2_c = '{x: v2_q.x, y: v2_q.y};

    tile_bbox #(
        .TILE_WIDTH   (TILE_WIDTH),
        .TILE_COLUMNS (TILE_COLUMNS),
        .TILE_ROWS    (TILE_ROWS)
    ) u_bbox (
        .p0_i          (p0_c),
        .p1_i          (p1_c),
        .p2_i          (p2_c),
        .col_lo_c_o    (col_lo_c),
        .col_hi_c_o    (col_hi_c),
        .row_lo_c_o    (row_lo_c),
        .row_hi_c_o    (row_hi_c),
        .offscreen_c_o (offscreen_c)
    );

`ifdef BINNER_BACKFACE_CULL_EN
    logic signed [COORD_W:0]  dx1_c, dy1_c, dx2_c, dy2_c;
    logic signed [AREA_W-1:0] area_c;

    // Twice the signed area; non-positive means back-facing or degenerate.
    always_comb begin
        dx1_c  = $signed({1'b0, v1_q.x}) - $signed({1'b0, v0_q.x});
        dy1_c  = $signed({1'b0, v1_q.y}) - $signed({1'b0, v0_q.y});
        dx2_c  = $signed({1'b0, v2_q.x}) - $signed({1'b0, v0_q.x});
        dy2_c  = $signed({1'b0, v2_q.y}) - $signed({1'b0, v0_q.y});
        area_c = AREA_W'(dx1_c) * AREA_W'(dy2_c) - AREA_W'(dx2_c) * AREA_W'(dy1_c);
        cull_c = area_c[AREA_W-1] || (area_c == '0);
    end
`else
    assign cull_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            m_vld_q  <= 1'b0;
            v0_q     <= '0;
            v1_q     <= '0;
            v2_q     <= '0;
            color_q  <= '0;
            col_lo_q <= '0;
            col_hi_q <= '0;
            row_hi_q <= '0;
            tile_x_q <= '0;
            tile_y_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bin_if.s_vld) begin
                        v0_q    <= bin_if.s_v0;
                        v1_q    <= bin_if.s_v1;
                        v2_q    <= bin_if.s_v2;
                        color_q <= bin_if.s_color;
                        state_q <= ST_SETUP;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    col_lo_q <= col_lo_c;
                    col_hi_q <= col_hi_c;
                    row_hi_q <= row_hi_c;
                    tile_x_q <= col_lo_c;
                    tile_y_q <= row_lo_c;
                    if (offscreen_c || cull_c) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_EMIT;
                        m_vld_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    // Row-major walk over the tile range, advancing only on handshake.
                    if (bin_if.m_rdy) begin
                        if (tile_x_q < col_hi_q) begin
                            tile_x_q <= tile_x_q + TILE_X_W'(1);
                        end else if (tile_y_q < row_hi_q) begin
                            tile_x_q <= col_lo_q;
                            tile_y_q <= tile_y_q + TILE_Y_W'(1);
                        end else begin
                            state_q <= ST_IDLE;
                            m_vld_q <= 1'b0;
                            rdy_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    m_vld_q <= 1'b0;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Ready is forced low combinationally while reset is held.
    assign bin_if.s_rdy  = rdy_q & rst_n;
    assign bin_if.m_vld  = m_vld_q;
    assign bin_if.m_v0   = v0_q;
    assign bin_if.m_v1   = v1_q;
    assign bin_if.m_v2   = v2_q;
    assign bin_if.m_meta = '{color: color_q, padding: '0, tile_y: tile_y_q, tile_x: tile_x_q};
    assign busy          = busy_q;

endmodule

// File: tb/tb_tile_binner.sv
// Directed table-driven bench for tile_binner plus hand-written backpressure/reset/busy sequences.
module tb_tile_binner;
    import raster_pkg::*;

`ifdef BINNER_BACKFACE_CULL_EN
    localparam bit CULL = 1'b1;
`else
    localparam bit CULL = 1'b0;
`endif
    localparam int NVEC   = 12;
    localparam int BUDGET = 1000;

    typedef struct {
        logic [9:0] x0, y0, x1, y1, x2, y2;
        logic [3:0] color;
        int cnt, cnt_cull, fx, fy, lx, ly;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tri_id   = 0;
    coord_3d_t cur_v0, cur_v1, cur_v2;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    tile_binner_if bif();

    tile_binner dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bin_if (bif.slave),
        .busy   (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2, input int c, input int cnt,
                                input int cnt_cull, input int fx, input int fy,
                                input int lx, input int ly);
        vec_t v;
        v.x0 = 10'(x0); v.y0 = 10'(y0); v.x1 = 10'(x1); v.y1 = 10'(y1);
        v.x2 = 10'(x2); v.y2 = 10'(y2); v.color = 4'(c);
        v.cnt = cnt; v.cnt_cull = cnt_cull; v.fx = fx; v.fy = fy; v.lx = lx; v.ly = ly;
        return v;
    endfunction

    function automatic logic [31:0] meta_of(input logic [3:0] c, input int tx, input int ty);
        polygon_t p;
        p.color = c; p.padding = 3'b000; p.tile_y = 4'(ty); p.tile_x = 5'(tx);
        return 32'(p);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the cycle after SETUP.
    task automatic send(input vec_t v);
        tri_id++;
        cur_v0 = '{x: v.x0, y: v.y0, z: 8'(tri_id * 3 + 1)};
        cur_v1 = '{x: v.x1, y: v.y1, z: 8'(tri_id * 5 + 2)};
        cur_v2 = '{x: v.x2, y: v.y2, z: 8'(tri_id * 7 + 3)};
        check("s_rdy_idle", 32'(bif.s_rdy), 32'd1);
        bif.s_vld = 1'b1; bif.s_v0 = cur_v0; bif.s_v1 = cur_v1; bif.s_v2 = cur_v2;
        bif.s_color = v.color;
        @(negedge clk);
        bif.s_vld = 1'b0;
        check("setup_m_vld", 32'(bif.m_vld), 32'd0);
        check("setup_busy", 32'(busy), 32'd1);
        check("setup_s_rdy", 32'(bif.s_rdy), 32'd0);
        @(negedge clk);
    endtask

    // Consumes items, checking each against the row-major walk of the expected range.
    task automatic collect(input vec_t v, input int stall_at, input int stall_len, output int n);
        int ex, ey, budget;
        logic [31:0] snap_meta, snap_v2;
        n = 0; ex = v.fx; ey = v.fy; budget = 0;
        bif.m_rdy = 1'b1;
        while (bif.m_vld === 1'b1 && budget < BUDGET) begin
            if (n == stall_at) begin
                bif.m_rdy = 1'b0;
                snap_meta = 32'(bif.m_meta);
                snap_v2   = 32'(bif.m_v2);
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    check("stall_m_vld", 32'(bif.m_vld), 32'd1);
                    check("stall_meta", 32'(bif.m_meta), snap_meta);
                    check("stall_v2", 32'(bif.m_v2), snap_v2);
                end
                bif.m_rdy = 1'b1;
            end
            check("item_meta", 32'(bif.m_meta), meta_of(v.color, ex, ey));
            if (n == 0) begin
                check("pass_v0", 32'(bif.m_v0), 32'(cur_v0));
                check("pass_v1", 32'(bif.m_v1), 32'(cur_v1));
                check("pass_v2", 32'(bif.m_v2), 32'(cur_v2));
            end
            n++;
            if (ex < v.lx) ex++;
            else begin ex = v.fx; ey++; end
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (budget >= BUDGET) begin
            n_fail++;
            $display("FAIL collect_timeout: got %0d cycles required fewer than %0d", budget, BUDGET);
        end
        check("s_rdy_after_last", 32'(bif.s_rdy), 32'd1);
        check("busy_after_last", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, exp_cnt;
        logic seen;
        vec_t va, vb;

        bif.s_vld = 1'b0; bif.s_v0 = '0; bif.s_v1 = '0; bif.s_v2 = '0; bif.s_color = '0;
        bif.m_rdy = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_rdy", 32'(bif.s_rdy), 32'd0);
        check("rst_m_vld", 32'(bif.m_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_s_rdy", 32'(bif.s_rdy), 32'd1);
        @(negedge clk);

        vecs[0]  = mk(10, 10, 20, 10, 10, 20,        5,   1,   1,  0,  0,  0,  0);
        vecs[1]  = mk(0, 0, 100, 0, 0, 40,           3,   8,   8,  0,  0,  3,  1);
        vecs[2]  = mk(600, 470, 1000, 470, 600, 1000, 1,  2,   2, 18, 14, 19, 14);
        vecs[3]  = mk(700, 10, 800, 10, 700, 20,     4,   0,   0,  0,  0,  0,  0);
        vecs[4]  = mk(10, 500, 20, 500, 10, 600,     6,   0,   0,  0,  0,  0,  0);
        vecs[5]  = mk(639, 479, 639, 479, 639, 479,  7,   1,   0, 19, 14, 19, 14);
        vecs[6]  = mk(10, 10, 10, 20, 20, 10,        2,   1,   0,  0,  0,  0,  0);
        vecs[7]  = mk(0, 0, 5, 5, 10, 10,            8,   1,   0,  0,  0,  0,  0);
        vecs[8]  = mk(31, 31, 32, 32, 33, 64,       15,   6,   6,  0,  0,  1,  2);
        vecs[9]  = mk(100, 200, 40, 70, 300, 90,     9,  45,  45,  1,  2,  9,  6);
        vecs[10] = mk(639, 0, 639, 479, 0, 479,     10, 300, 300,  0,  0, 19, 14);
        vecs[11] = mk(1023, 1023, 1023, 1023, 1023, 1023, 11, 0, 0, 0, 0, 0, 0);

        // Back-to-back table run: each triangle is sent the cycle s_rdy returns.
        for (int i = 0; i < NVEC; i++) begin
            exp_cnt = CULL ? vecs[i].cnt_cull : vecs[i].cnt;
            send(vecs[i]);
            check($sformatf("v%0d_first_m_vld", i), 32'(bif.m_vld), (exp_cnt > 0) ? 32'd1 : 32'd0);
            collect(vecs[i], -1, 0, n);
            check($sformatf("v%0d_item_count", i), 32'(n), 32'(exp_cnt));
        end

        // Backpressure: hold m_rdy low for 5 cycles on the fourth item.
        send(vecs[1]);
        collect(vecs[1], 3, 5, n);
        check("stall_item_count", 32'(n), 32'd8);

        // Reset while the second item is presented aborts the triangle.
        send(vecs[1]);
        check("abort_item0", 32'(bif.m_meta), 32'h0000_3000);
        @(negedge clk);
        check("abort_item1", 32'(bif.m_meta), 32'h0000_3001);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_m_vld", 32'(bif.m_vld), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_s_rdy_low", 32'(bif.s_rdy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("abort_s_rdy_release", 32'(bif.s_rdy), 32'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bif.m_vld !== 1'b0) seen = 1'b1;
        end
        check("abort_no_more_items", 32'(seen), 32'd0);
        send(vecs[0]);
        check("post_abort_first", 32'(bif.m_vld), 32'd1);
        collect(vecs[0], -1, 0, n);
        check("post_abort_count", 32'(n), 32'd1);

        // s_vld held through a busy triangle: second triangle only taken once idle.
        va = vecs[0];
        vb = vecs[0]; vb.color = 4'd9;
        bif.s_vld = 1'b1; bif.s_v0 = cur_v0; bif.s_v1 = cur_v1; bif.s_v2 = cur_v2;
        bif.s_color = va.color;
        @(negedge clk);
        bif.s_color = vb.color;
        check("held_setup_s_rdy", 32'(bif.s_rdy), 32'd0);
        @(negedge clk);
        check("held_a_m_vld", 32'(bif.m_vld), 32'd1);
        check("held_a_meta", 32'(bif.m_meta), 32'h0000_5000);
        @(negedge clk);
        check("held_a_done_s_rdy", 32'(bif.s_rdy), 32'd1);
        check("held_a_done_m_vld", 32'(bif.m_vld), 32'd0);
        @(negedge clk);
        bif.s_vld = 1'b0;
        check("held_b_setup_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("held_b_m_vld", 32'(bif.m_vld), 32'd1);
        check("held_b_meta", 32'(bif.m_meta), 32'h0000_9000);
        @(negedge clk);
        check("held_b_done_m_vld", 32'(bif.m_vld), 32'd0);
        check("held_b_done_s_rdy", 32'(bif.s_rdy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
